// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC result drain: result beat layout and FSM states.
package mac_pkg;

  localparam int DATA_W    = 64;
  localparam int DEPTH_DEF = 8;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } mac_res_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_t;

endpackage

// File: rtl/mac_result_drain_if.sv
// Bundle of job control, MAC result beats, issue credit and store-side handshake signals.
interface mac_result_drain_if
  import mac_pkg::*;
#(
  parameter int IDX_W = 16
) ();

  logic              job_start;
  logic [IDX_W-1:0]  job_len;
  logic              issue_valid;
  logic              issue_ready;
  logic              store_valid;
  logic [DATA_W-1:0] res_out;
  logic              error_flag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_error;
  logic [IDX_W-1:0]  out_index;
  logic              busy;
  logic              done;
  logic              spurious_err;
  logic              overflow_err;

  // Handshakes (issue_*, out_*): a transfer happens on a rising edge where valid and
  // ready are both 1; valid never waits on ready, and an offered head holds its
  // payload stable until it is taken. store_valid has no ready: the pipeline cannot stall.
  modport master (
    output job_start, job_len, issue_valid, store_valid, res_out, error_flag, out_ready,
    input  issue_ready, out_valid, out_data, out_error, out_index, busy, done,
           spurious_err, overflow_err
  );

  modport slave (
    input  job_start, job_len, issue_valid, store_valid, res_out, error_flag, out_ready,
    output issue_ready, out_valid, out_data, out_error, out_index, busy, done,
           spurious_err, overflow_err
  );

endinterface

// File: rtl/mac_result_drain_fifo.sv
// First-word-fall-through FIFO of result beats; the head is readable whenever empty_o is low.
module drain_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  mac_res_t               wr_data_i,
  input  logic                   pop_i,
  output mac_res_t               rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mac_res_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push then.
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Receive end of the MAC pipeline: buffers result beats, grants issue credits so every
// in-flight op has a reserved slot, and tracks job progress to a done pulse.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_result_drain_if.slave   bus,
  output drain_state_t        state_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  drain_state_t     state_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] issued_q;
  logic [IDX_W-1:0] accepted_q;
  logic [IDX_W-1:0] index_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             done_q;
  logic             spur_q;
  logic             ovf_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_ok;
  logic             issue_fire;
  logic             pop;
  logic             store_dec;
  mac_res_t         beat;
  mac_res_t         head;

  assign beat = {bus.error_flag, bus.res_out};

  drain_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (bus.store_valid),
    .wr_data_i (beat),
    .pop_i     (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Credit is DEPTH minus buffered minus in-flight; spurious beats can push the sum past
  // DEPTH, so compare the widened sum instead of subtracting.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign issue_ok   = (state_q == RUN) && (occupancy < (CNT_W+1)'(DEPTH)) && (issued_q < len_q);
  assign issue_fire = bus.issue_valid && issue_ok;
  assign pop        = !fifo_empty && bus.out_ready;
  assign store_dec  = bus.store_valid && (inflight_q != '0);
  assign inflight_d = inflight_q + CNT_W'(issue_fire) - CNT_W'(store_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      index_q    <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      spur_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      if (bus.store_valid && (inflight_q == '0)) spur_q <= 1'b1;
      if (bus.store_valid && fifo_full && !pop)  ovf_q  <= 1'b1;
      if (issue_fire) issued_q <= issued_q + IDX_W'(1);
      if (pop) begin
        accepted_q <= accepted_q + IDX_W'(1);
        index_q    <= index_q + IDX_W'(1);
      end
      case (state_q)
        IDLE: if (bus.job_start) begin
          state_q    <= RUN;
          len_q      <= (bus.job_len == '0) ? IDX_W'(1) : bus.job_len;
          issued_q   <= '0;
          accepted_q <= '0;
          index_q    <= '0;
        end
        RUN: if (accepted_q == len_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready  = issue_ok;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_data     = fifo_empty ? '0 : head.data;
  assign bus.out_error    = fifo_empty ? 1'b0 : head.err;
  assign bus.out_index    = index_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.spurious_err = spur_q;
  assign bus.overflow_err = ovf_q;
  assign state_o          = state_q;

endmodule
